// File: rtl/audio_pkg.sv
// Shared definitions for the I2S DAC player: default widths, player FSM states
// and an elaboration-time log2 helper.
package audio_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for audio samples; flush empties it in one cycle.
// A push while full is taken only when a pop happens in the same cycle.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W_DEF,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign o_full  = (level_q == (AW+1)'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign pop_ok  = i_pop && !o_empty;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/audio_dac_player.sv
// Buffers mono samples and serialises them as I2S (codec is clock master),
// duplicating each sample into the right channel; tracks underruns/overflows.
module audio_dac_player
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int HOLD_LAST  = 0,
  localparam int LVL_W     = clog2(FIFO_DEPTH) + 1,
  localparam int BC_W      = clog2(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  output logic              o_dacdat,
  output logic              o_ready,
  output logic [LVL_W-1:0]  o_fifo_level,
  output logic [CNT_W-1:0]  o_underrun_cnt,
  output logic [CNT_W-1:0]  o_overflow_cnt
);

  // [0],[1] synchronise, [2] is the previous value for edge detection
  logic [2:0] bclk_q, lrck_q;
  logic       bfall, lrx, lrf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_q <= '0;
      lrck_q <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], i_bclk};
      lrck_q <= {lrck_q[1:0], i_daclrck};
    end
  end

  assign bfall = bclk_q[2] & ~bclk_q[1];
  assign lrx   = lrck_q[2] ^ lrck_q[1];
  assign lrf   = lrck_q[2] & ~lrck_q[1];

  logic              fifo_full, fifo_empty, pop, push, ovf, udr;
  logic [DATA_W-1:0] fifo_data;

  assign pop  = i_en && lrf && !fifo_empty;
  assign push = i_valid && i_en && (!fifo_full || pop);
  assign ovf  = i_valid && i_en && fifo_full && !pop;
  assign udr  = i_en && lrf && fifo_empty;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (!i_en),
    .i_push  (push),
    .i_data  (i_data),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  assign o_ready = !fifo_full;

  // Last-sample register tracks what the left word carried, so the right
  // word always duplicates it (including a zero sent on underrun).
  logic [DATA_W-1:0] sh_q, last_q, load_val;

  always_comb begin
    load_val = last_q;
    if (lrf) load_val = fifo_empty ? ((HOLD_LAST != 0) ? last_q : '0) : fifo_data;
  end

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic             dacdat_q, dacdat_d;
  logic [CNT_W-1:0] udr_cnt_q, ovf_cnt_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    dacdat_d = dacdat_q;
    if (!i_en) begin
      state_d  = S_IDLE;
      dacdat_d = 1'b0;
    end else if (lrx) begin
      state_d = S_DELAY;
    end else if (bfall) begin
      case (state_q)
        S_DELAY: begin
          dacdat_d = sh_q[DATA_W-1];
          bitcnt_d = BC_W'(DATA_W - 1);
          state_d  = S_SHIFT;
        end
        S_SHIFT: begin
          if (bitcnt_q == '0) begin
            dacdat_d = 1'b0;
            state_d  = S_PAD;
          end else begin
            dacdat_d = sh_q[bitcnt_q - 1'b1];
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      dacdat_q  <= 1'b0;
      sh_q      <= '0;
      last_q    <= '0;
      udr_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      dacdat_q <= dacdat_d;
      if (i_en && lrx) begin
        sh_q   <= load_val;
        last_q <= load_val;
      end
      if (udr && (udr_cnt_q != '1)) udr_cnt_q <= udr_cnt_q + 1'b1;
      if (ovf && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign o_dacdat       = dacdat_q;
  assign o_underrun_cnt = udr_cnt_q;
  assign o_overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_audio_dac_player.sv
// Directed bench: two players (zero-fill and hold-last underrun) on shared
// stimulus, BCLK = clk/8, LRCK edges aligned with BCLK falls.
module tb_audio_dac_player;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, valid = 1'b0;
  logic        bclk = 1'b0, lrck = 1'b0;
  logic [15:0] data = '0;
  logic        dac0, dac1, rdy0, rdy1;
  logic [2:0]  lvl0, lvl1;
  logic [7:0]  ur0, ur1, ov0, ov1;
  logic [23:0] w0, w1;
  int          n_cmp = 0, n_mis = 0;

  always #5 clk = ~clk;

  audio_dac_player #(.HOLD_LAST(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .i_data(data),
    .i_bclk(bclk), .i_daclrck(lrck), .o_dacdat(dac0), .o_ready(rdy0),
    .o_fifo_level(lvl0), .o_underrun_cnt(ur0), .o_overflow_cnt(ov0)
  );

  audio_dac_player #(.HOLD_LAST(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(valid), .i_data(data),
    .i_bclk(bclk), .i_daclrck(lrck), .o_dacdat(dac1), .o_ready(rdy1),
    .o_fifo_level(lvl1), .o_underrun_cnt(ur1), .o_overflow_cnt(ov1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // One BCLK period starting with a fall; optional push lands on the lrf pop cycle.
  task automatic slot(input logic lr, input logic pv, input logic [15:0] pd);
    bclk = 1'b0;
    lrck = lr;
    repeat (2) @(negedge clk);
    if (pv) begin
      valid = 1'b1;
      data  = pd;
    end
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic half(input logic lr, input logic pv, input logic [15:0] pd);
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 24; i++) begin
      slot(lr, pv && (i == 0), pd);
      w0 = {w0[22:0], dac0};
      w1 = {w1[22:0], dac1};
    end
  endtask

  function automatic logic [23:0] exp_w(input logic [15:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  initial begin
    logic [15:0] exp4 [4];
    exp4[0] = 16'h2222; exp4[1] = 16'h3333; exp4[2] = 16'h4444; exp4[3] = 16'h7777;

    repeat (3) @(negedge clk);
    check("rst dacdat", dac0, 0);
    check("rst level", lvl0, 0);
    check("rst ready", rdy0, 1);
    check("rst underrun", ur0, 0);
    check("rst overflow", ov0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic left/right word
    push(16'hA5C3);
    check("t2 level", lvl0, 1);
    half(1'b1, 1'b0, '0);
    check("t2 first right", w0, 0);
    half(1'b0, 1'b0, '0);
    check("t2 left word", w0, exp_w(16'hA5C3));
    check("t2 level after pop", lvl0, 0);
    half(1'b1, 1'b0, '0);
    check("t2 right word", w0, exp_w(16'hA5C3));

    // Underrun: zero fill vs hold last
    for (int k = 0; k < 3; k++) begin
      half(1'b0, 1'b0, '0);
      check("t3 left zero", w0, 0);
      check("t3 left hold", w1, exp_w(16'hA5C3));
      half(1'b1, 1'b0, '0);
      check("t3 right zero", w0, 0);
    end
    check("t3 underrun", ur0, 3);
    check("t3 underrun hold", ur1, 3);
    push(16'h7FFF);
    half(1'b0, 1'b0, '0);
    check("t3 7fff left", w1, exp_w(16'h7FFF));
    half(1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      half(1'b0, 1'b0, '0);
      check("t3 hold left", w1, exp_w(16'h7FFF));
      check("t3 zero left", w0, 0);
      half(1'b1, 1'b0, '0);
      check("t3 hold right", w1, exp_w(16'h7FFF));
    end
    check("t3 underrun2", ur0, 6);
    check("t3 underrun2 hold", ur1, 6);

    // Overflow
    for (int k = 0; k < 6; k++) push(16'h1111 * 16'(k + 1));
    check("t4 level", lvl0, 4);
    check("t4 ready", rdy0, 0);
    check("t4 overflow", ov0, 2);

    // Push on the pop cycle while full
    half(1'b0, 1'b1, 16'h7777);
    check("t5 left word", w0, exp_w(16'h1111));
    check("t5 level", lvl0, 4);
    check("t5 overflow", ov0, 2);
    half(1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      half(1'b0, 1'b0, '0);
      check("t4 order", w0, exp_w(exp4[k]));
      half(1'b1, 1'b0, '0);
    end
    check("t4 level drained", lvl0, 0);
    check("t4 no underrun", ur0, 6);

    // Reset mid-word
    push(16'hFFFF);
    push(16'h1234);
    for (int i = 0; i < 6; i++) slot(1'b0, 1'b0, '0);
    check("t1 shifting", dac0, 1);
    check("t1 level before", lvl0, 1);
    rst_n = 1'b0;
    #1;
    check("t1 dacdat", dac0, 0);
    check("t1 level", lvl0, 0);
    check("t1 ready", rdy0, 1);
    check("t1 underrun", ur0, 0);
    check("t1 overflow", ov0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(16'hC3A5);
    half(1'b1, 1'b0, '0);
    half(1'b0, 1'b0, '0);
    check("t1 word after reset", w0, exp_w(16'hC3A5));
    check("t1 underrun after", ur0, 0);

    // Enable drop mid-word
    half(1'b1, 1'b0, '0);
    push(16'hFFFF);
    push(16'h1111);
    for (int i = 0; i < 6; i++) slot(1'b0, 1'b0, '0);
    check("t6 shifting", dac0, 1);
    check("t6 level before", lvl0, 1);
    en = 1'b0;
    @(negedge clk);
    check("t6 dacdat off", dac0, 0);
    check("t6 flushed", lvl0, 0);
    push(16'h2222);
    check("t6 push ignored", lvl0, 0);
    check("t6 overflow held", ov0, 0);
    for (int i = 0; i < 18; i++) slot(1'b0, 1'b0, '0);
    check("t6 idle output", dac0, 0);
    en = 1'b1;
    push(16'h8000);
    half(1'b1, 1'b0, '0);
    half(1'b0, 1'b0, '0);
    check("t6 word 8000", w0, exp_w(16'h8000));
    check("t6 underrun", ur0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
